// File: rtl/mmm_pkg.sv
// Shared encodings and sizing helpers for the Montgomery multiplier sequencer.
package mmm_pkg;

  localparam logic [2:0] MMM_ST_IDLE = 3'd0;
  localparam logic [2:0] MMM_ST_LOAD = 3'd1;
  localparam logic [2:0] MMM_ST_ITER = 3'd2;
  localparam logic [2:0] MMM_ST_SUB  = 3'd3;
  localparam logic [2:0] MMM_ST_DONE = 3'd4;

  // Digit-index width; never below one bit so a single-digit build still has a port.
  function automatic int unsigned mmm_cw(input int unsigned n, input int unsigned w);
    int unsigned d;
    d = n / w;
    if (d <= 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(d);
    end
  endfunction

  localparam int unsigned MMM_CW = mmm_cw(32'd32, 32'd1);

  // Iteration count with out-of-range lengths treated as full width.
  function automatic int unsigned mmm_iters(input int unsigned len, input int unsigned n,
                                            input int unsigned w);
    int unsigned eff;
    if ((len == 32'd0) || (len > n)) begin
      eff = n;
    end else begin
      eff = len;
    end
    return (eff + w - 32'd1) / w;
  endfunction

endpackage

// File: rtl/mmm_iter_counter.sv
// Digit iteration counter with synchronous clear, enable and terminal compare.
module mmm_iter_counter #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rn,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] last_idx,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  logic [CW-1:0] r_cnt;

  // Count register; clear wins over enable.
  always_ff @(posedge clk) begin
    if (rn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt = r_cnt;
  assign tc  = (r_cnt == last_idx);

endmodule

// File: rtl/mmm_seq_control.sv
// Sequencer for the radix-2^W sequential Montgomery multiplier datapath.
// Optional final subtraction cycle enabled by defining MMM_CTRL_FINAL_SUB_EN.
module mmm_seq_control
  import mmm_pkg::*;
#(
  parameter  int N  = 32,
  parameter  int W  = 1,
  localparam int LW = $clog2(N + 1),
  localparam int CW = mmm_cw(N, W)
) (
  input  logic          clk,
  input  logic          rn,
  input  logic          start,
  input  logic          abort,
  input  logic [LW-1:0] len,
  output logic          clr,
  output logic          active,
  output logic [CW-1:0] iter,
  output logic          last,
  output logic          sub_en,
  output logic          ready,
  output logic          busy
);

  typedef enum logic [2:0] {
    ST_IDLE = MMM_ST_IDLE,
    ST_LOAD = MMM_ST_LOAD,
    ST_ITER = MMM_ST_ITER,
    ST_SUB  = MMM_ST_SUB,
    ST_DONE = MMM_ST_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_last_idx;
  logic [CW-1:0] w_last_idx;
  logic [CW-1:0] w_cnt;
  logic          w_tc;
  logic          w_start_acc;
  logic          w_cnt_clr;
  logic          w_cnt_en;

  assign w_start_acc = start & ~abort;

  // Terminal index I-1 derived from the requested length.
  always_comb begin
    w_last_idx = CW'(mmm_iters(32'(len), 32'(N), 32'(W)) - 32'd1);
  end

  // Next-state decode: abort beats start, start restarts from any state.
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = ST_IDLE;
    end else if (start) begin
      w_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_IDLE: w_next = ST_IDLE;
        ST_LOAD: w_next = ST_ITER;
        ST_ITER: begin
          if (w_tc) begin
`ifdef MMM_CTRL_FINAL_SUB_EN
            w_next = ST_SUB;
`else
            w_next = ST_DONE;
`endif
          end else begin
            w_next = ST_ITER;
          end
        end
        ST_SUB:  w_next = ST_DONE;
        ST_DONE: w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Terminal index is captured only when a start is accepted.
  always_ff @(posedge clk) begin
    if (rn) begin
      r_last_idx <= '0;
    end else if (w_start_acc) begin
      r_last_idx <= w_last_idx;
    end else begin
      r_last_idx <= r_last_idx;
    end
  end

  // Counter is zero whenever the FSM is not iterating, so iter needs no extra hold logic.
  assign w_cnt_clr = (w_next != ST_ITER);
  assign w_cnt_en  = (r_state == ST_ITER);

  mmm_iter_counter #(
    .CW(CW)
  ) u_iter_counter (
    .clk      (clk),
    .rn       (rn),
    .clr      (w_cnt_clr),
    .en       (w_cnt_en),
    .last_idx (r_last_idx),
    .cnt      (w_cnt),
    .tc       (w_tc)
  );

  assign clr    = (r_state == ST_LOAD);
  assign active = (r_state == ST_ITER);
  assign iter   = active ? w_cnt : '0;
  assign last   = active & w_tc;
`ifdef MMM_CTRL_FINAL_SUB_EN
  assign sub_en = (r_state == ST_SUB);
`else
  assign sub_en = 1'b0;
`endif
  assign ready  = (r_state == ST_DONE);
  assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mmm_seq_control.sv
// Directed bench for mmm_seq_control, W=1 and W=4 instances side by side.
module tb_mmm_seq_control;

`ifdef MMM_CTRL_FINAL_SUB_EN
  localparam int SUBC = 1;
`else
  localparam int SUBC = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn, start1, abort1, start4, abort4;
  logic [5:0] len1, len4;
  logic       clr1, act1, last1, sub1, rdy1, busy1;
  logic [4:0] iter1;
  logic       clr4, act4, last4, sub4, rdy4, busy4;
  logic [2:0] iter4;

  int total = 0;
  int bad   = 0;

  mmm_seq_control #(.N(32), .W(1)) dut (
    .clk(clk), .rn(rn), .start(start1), .abort(abort1), .len(len1),
    .clr(clr1), .active(act1), .iter(iter1), .last(last1),
    .sub_en(sub1), .ready(rdy1), .busy(busy1)
  );

  mmm_seq_control #(.N(32), .W(4)) dut4 (
    .clk(clk), .rn(rn), .start(start4), .abort(abort4), .len(len4),
    .clr(clr4), .active(act4), .iter(iter4), .last(last4),
    .sub_en(sub4), .ready(rdy4), .busy(busy4)
  );

  // Expected {clr,active,iter[4:0],last,sub_en,ready,busy} k cycles after start.
  function automatic logic [10:0] exp_vec(input int k, input int i_n);
    logic c, a, l, s, r, b;
    logic [4:0] it;
    c  = (k == 1);
    a  = (k >= 2) && (k <= 1 + i_n);
    it = a ? 5'(k - 2) : 5'd0;
    l  = (k == 1 + i_n);
    s  = (SUBC == 1) && (k == 2 + i_n);
    r  = (k == 2 + i_n + SUBC);
    b  = (k >= 1) && (k <= 2 + i_n + SUBC);
    return {c, a, it, l, s, r, b};
  endfunction

  function automatic logic [10:0] obs1();
    return {clr1, act1, iter1, last1, sub1, rdy1, busy1};
  endfunction

  function automatic logic [10:0] obs4();
    return {clr4, act4, 2'b00, iter4, last4, sub4, rdy4, busy4};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] o;
    o = obs1();
    total++;
    if (o !== 11'd0) begin
      bad++;
      $display("FAIL reset_w1 got=%b want=%b", o, 11'd0);
    end
    o = obs4();
    total++;
    if (o !== 11'd0) begin
      bad++;
      $display("FAIL reset_w4 got=%b want=%b", o, 11'd0);
    end
    rn = 1'b0;
    tick();
  endtask

  task automatic test_full_op(input bit use4, input logic [5:0] lv, input int i_n,
                              input string nm);
    logic [10:0] o, e;
    for (int k = 0; k <= i_n + 5; k++) begin
      o = use4 ? obs4() : obs1();
      e = exp_vec(k, i_n);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s k=%0d got=%b want=%b", nm, k, o, e);
      end
      if (use4) begin
        start4 = (k == 0);
        len4   = lv;
      end else begin
        start1 = (k == 0);
        len1   = lv;
      end
      tick();
    end
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic test_restart();
    logic [10:0] o, e;
    for (int k = 0; k <= 46; k++) begin
      o = obs1();
      e = (k <= 10) ? exp_vec(k, 32) : exp_vec(k - 10, 8);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL restart k=%0d got=%b want=%b", k, o, e);
      end
      start1 = (k == 0) || (k == 10);
      len1   = (k == 10) ? 6'd8 : 6'd0;
      tick();
    end
    start1 = 1'b0;
  endtask

  task automatic test_abort();
    logic [10:0] o, e;
    for (int k = 0; k <= 10; k++) begin
      o = obs1();
      e = (k <= 5) ? exp_vec(k, 32) : 11'd0;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL abort k=%0d got=%b want=%b", k, o, e);
      end
      start1 = (k == 0);
      abort1 = (k == 5);
      len1   = 6'd0;
      tick();
    end
    for (int k = 0; k <= 8; k++) begin
      o = obs1();
      e = (k <= 4) ? exp_vec(k, 32) : 11'd0;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL abort_vs_start k=%0d got=%b want=%b", k, o, e);
      end
      start1 = (k == 0) || (k == 4);
      abort1 = (k == 4);
      len1   = (k == 4) ? 6'd8 : 6'd0;
      tick();
    end
    start1 = 1'b1;
    abort1 = 1'b1;
    tick();
    start1 = 1'b0;
    abort1 = 1'b0;
    o = obs1();
    total++;
    if (o !== 11'd0) begin
      bad++;
      $display("FAIL abort_start_idle got=%b want=%b", o, 11'd0);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] o, e;
    for (int k = 0; k <= 12; k++) begin
      o = obs1();
      e = (k <= 8) ? exp_vec(k, 32) : 11'd0;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset_mid k=%0d got=%b want=%b", k, o, e);
      end
      start1 = (k == 0);
      len1   = 6'd0;
      rn     = (k == 8);
      tick();
    end
    rn = 1'b0;
    test_full_op(1'b0, 6'd5, 5, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [10:0] o, e;
    int r;
    r = 2 + 32 + SUBC;
    for (int k = 0; k <= 2 * r + 2; k++) begin
      o = obs1();
      e = (k <= r) ? exp_vec(k, 32) : exp_vec(k - r, 32);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL back_to_back k=%0d got=%b want=%b", k, o, e);
      end
      start1 = (k == 0) || (k == r);
      len1   = 6'd40;
      tick();
    end
    start1 = 1'b0;
  endtask

  initial begin
    rn = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; len1 = 6'd0;
    start4 = 1'b0; abort4 = 1'b0; len4 = 6'd0;
    tick();
    tick();
    test_reset();
    test_full_op(1'b0, 6'd0,  32, "w1_len0");
    test_full_op(1'b0, 6'd1,  1,  "w1_len1");
    test_full_op(1'b0, 6'd40, 32, "w1_len40");
    test_full_op(1'b1, 6'd13, 4,  "w4_len13");
    test_full_op(1'b1, 6'd4,  1,  "w4_len4");
    test_full_op(1'b1, 6'd33, 8,  "w4_len33");
    test_full_op(1'b1, 6'd0,  8,  "w4_len0");
    test_restart();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
